// File: rtl/sensor_cond.sv
// sensor_cond: front end of the assist loop. Filters motor current and crank
// torque, measures cadence from the crank pulse train, forms a target current
// from torque, incline and assist level, and registers error = target - current.
// Optional feature macro: SENSOR_COND_LOW_BATT_EN (battery filter with a
// low-battery cut of the target). Without it, batt is ignored.
module sensor_cond #(
  parameter bit FAST_SIM = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sample_vld,
  input  logic [11:0] curr,
  input  logic [11:0] torque,
  input  logic [11:0] batt,
  input  logic [12:0] incline,
  input  logic [2:0]  scale,
  input  logic        cadence_raw,
  output logic [12:0] error,
  output logic        not_pedaling,
  output logic [11:0] avg_curr,
  output logic [11:0] avg_torque
);

  localparam int WIN_W = FAST_SIM ? 12 : 22;

  // Cadence measurement state
  logic [WIN_W-1:0] win_q;
  logic [2:0]       cad_sync_q;
  logic [7:0]       pulse_cnt_q, pulse_cnt_d;
  logic [7:0]       cadence_q, cadence_d;
  logic             cad_edge;
  logic             win_wrap;

  // Filter accumulators
  logic [13:0] acc_curr_q, acc_curr_d;
  logic [16:0] acc_torq_q, acc_torq_d;

  // Pipeline stage 1
  logic [11:0] torque_off;
  logic [9:0]  inc_sat;
  logic [10:0] inc_off;
  logic [8:0]  factor;
  logic [20:0] prod1;
  logic [11:0] t1_d, t1_q;
  logic [11:0] curr_p_q;
  logic [2:0]  scale_q;
  logic        np_p_q;

  // Pipeline stage 2
  logic [14:0] prod2;
  logic [11:0] target;
  logic [12:0] error_d, error_q;

  // Sample 3 flops deep: two for metastability, the third for edge detect.
  assign cad_edge = cad_sync_q[1] & ~cad_sync_q[2];
  assign win_wrap = &win_q;

  // Crank pulse synchronizer and the free-running measurement window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q      <= '0;
      cad_sync_q <= '0;
    end else begin
      win_q      <= win_q + WIN_W'(1);
      cad_sync_q <= {cad_sync_q[1:0], cadence_raw};
    end
  end

  // Saturating pulse count per window; an edge on the wrap cycle opens the next window.
  always_comb begin
    pulse_cnt_d = pulse_cnt_q;
    cadence_d   = cadence_q;
    if (win_wrap) begin
      cadence_d   = pulse_cnt_q;
      pulse_cnt_d = {7'd0, cad_edge};
    end else if (cad_edge && (pulse_cnt_q != 8'hFF)) begin
      pulse_cnt_d = pulse_cnt_q + 8'd1;
    end
  end

  // Cadence registers; the pedaling flag is a decode of the latched window count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_cnt_q <= '0;
      cadence_q   <= '0;
    end else begin
      pulse_cnt_q <= pulse_cnt_d;
      cadence_q   <= cadence_d;
    end
  end

  assign not_pedaling = (cadence_q < 8'd2);

  // First-order low-pass filters, updated only on sample strobes.
  always_comb begin
    acc_curr_d = acc_curr_q;
    acc_torq_d = acc_torq_q;
    if (sample_vld) begin
      acc_curr_d = acc_curr_q - {2'b00, acc_curr_q[13:2]} + {2'b00, curr};
      acc_torq_d = acc_torq_q - {5'd0, acc_torq_q[16:5]} + {5'd0, torque};
    end
  end

  // Filter accumulator registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_curr_q <= '0;
      acc_torq_q <= '0;
    end else begin
      acc_curr_q <= acc_curr_d;
      acc_torq_q <= acc_torq_d;
    end
  end

  assign avg_curr   = acc_curr_q[13:2];
  assign avg_torque = acc_torq_q[16:5];

`ifdef SENSOR_COND_LOW_BATT_EN
  logic [13:0] acc_batt_q, acc_batt_d;
  logic        batt_low_q;

  // Battery filter, same 1/4 weight as the current filter.
  always_comb begin
    acc_batt_d = acc_batt_q;
    if (sample_vld) begin
      acc_batt_d = acc_batt_q - {2'b00, acc_batt_q[13:2]} + {2'b00, batt};
    end
  end

  // Battery accumulator and low-battery flag aligned with pipeline stage 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_batt_q <= '0;
      batt_low_q <= 1'b0;
    end else begin
      acc_batt_q <= acc_batt_d;
      batt_low_q <= (acc_batt_q[13:2] < 12'hA98);
    end
  end
`else
  logic unused_batt;
  assign unused_batt = ^batt;
`endif

  // Stage 1: torque offset times incline factor (incline clipped to 0..511 after +256).
  always_comb begin
    torque_off = (avg_torque >= 12'h380) ? (avg_torque - 12'h380) : 12'h000;
    if (!incline[12] && (incline[11:9] != 3'b000)) begin
      inc_sat = 10'h1FF;
    end else if (incline[12] && (incline[11:9] != 3'b111)) begin
      inc_sat = 10'h200;
    end else begin
      inc_sat = incline[9:0];
    end
    inc_off = {inc_sat[9], inc_sat} + 11'd256;
    if (inc_off[10]) begin
      factor = 9'd0;
    end else if (inc_off[9]) begin
      factor = 9'h1FF;
    end else begin
      factor = inc_off[8:0];
    end
    prod1 = {9'd0, torque_off} * {12'd0, factor};
    t1_d  = 12'(prod1 >> 9);
  end

  // Stage 1 registers; current, scale and pedaling flag travel alongside t1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t1_q     <= '0;
      curr_p_q <= '0;
      scale_q  <= '0;
      np_p_q   <= 1'b1;
    end else begin
      t1_q     <= t1_d;
      curr_p_q <= avg_curr;
      scale_q  <= scale;
      np_p_q   <= not_pedaling;
    end
  end

  // Stage 2: apply assist level, saturate, gate, and subtract filtered current.
  always_comb begin
    prod2  = {3'd0, t1_q} * {12'd0, scale_q};
    target = prod2[14] ? 12'hFFF : 12'(prod2 >> 2);
    if (np_p_q) begin
      target = 12'h000;
    end
`ifdef SENSOR_COND_LOW_BATT_EN
    if (batt_low_q) begin
      target = 12'h000;
    end
`endif
    error_d = {1'b0, target} - {1'b0, curr_p_q};
  end

  // Error output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error_q <= '0;
    end else begin
      error_q <= error_d;
    end
  end

  assign error = error_q;

endmodule

// File: tb/tb_sensor_cond.sv
// tb_sensor_cond: directed sequence with randomized phases, checked against a
// cycle-level behavioural model of the filters, cadence windows and target math.
module tb_sensor_cond;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_vld = 1'b0;
  logic [11:0] curr = '0;
  logic [11:0] torque = '0;
  logic [11:0] batt = '0;
  logic [12:0] incline = '0;
  logic [2:0]  scale = '0;
  logic        cadence_raw = 1'b0;
  logic [12:0] error;
  logic        not_pedaling;
  logic [11:0] avg_curr;
  logic [11:0] avg_torque;

  sensor_cond #(.FAST_SIM(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .sample_vld(sample_vld), .curr(curr),
    .torque(torque), .batt(batt), .incline(incline), .scale(scale),
    .cadence_raw(cadence_raw), .error(error), .not_pedaling(not_pedaling),
    .avg_curr(avg_curr), .avg_torque(avg_torque)
  );

  always #10 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Drive settings
  logic        d_vld = 1'b0;
  logic [11:0] d_curr = '0, d_torque = '0, d_batt = 12'hB00;
  logic [12:0] d_incline = '0;
  logic [2:0]  d_scale = '0;
  int          ppw = 0;
  logic        wrap_en = 1'b0;

  // Model state
  int   cyc;
  int   m_acc_c, m_acc_t, m_acc_b;
  int   m_np;
  int   win_edges [0:31];
  logic prev_lvl;
  int   stable_cnt;
  logic [12:0] last_inc;
  logic [2:0]  last_scale;

  task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic model_reset();
    m_acc_c = 0; m_acc_t = 0; m_acc_b = 0; m_np = 1; cyc = 0;
    prev_lvl = 1'b0; stable_cnt = 0;
    last_inc = d_incline; last_scale = d_scale;
    for (int i = 0; i < 32; i++) win_edges[i] = 0;
  endtask

  // Expected error from the specification's arithmetic on the model's filter state.
  function automatic logic [12:0] exp_err();
    int at, ac, toff, inc, f, t1, p2, tgt;
    at = m_acc_t / 32;
    ac = m_acc_c / 4;
    toff = (at >= 896) ? at - 896 : 0;
    inc = int'(d_incline);
    if (d_incline[12]) inc = inc - 8192;
    if (inc > 511) inc = 511;
    if (inc < -512) inc = -512;
    f = inc + 256;
    if (f < 0) f = 0;
    if (f > 511) f = 511;
    t1 = (toff * f) / 512;
    p2 = t1 * int'(d_scale);
    tgt = (p2 >= 16384) ? 4095 : p2 / 4;
    if (m_np != 0) tgt = 0;
`ifdef SENSOR_COND_LOW_BATT_EN
    if ((m_acc_b / 4) < 'hA98) tgt = 0;
`endif
    return 13'((tgt - ac) & 'h1FFF);
  endfunction

  // One clock: drive inputs, take the edge, advance the model, sample 1 unit later.
  task automatic tick();
    logic lvl;
    int   pos, w, cnt;
    logic changed;
    pos = cyc % 4096;
    lvl = 1'b0;
    if (pos >= 200 && pos < 200 + 8 * ppw && ((pos - 200) % 8) < 4) lvl = 1'b1;
    if (wrap_en && pos >= 4093) lvl = 1'b1;
    if (lvl && !prev_lvl) begin
      w = (cyc + 3) / 4096;
      if (w < 32) win_edges[w]++;
    end
    prev_lvl = lvl;
    cadence_raw = lvl;
    sample_vld = d_vld; curr = d_curr; torque = d_torque; batt = d_batt;
    incline = d_incline; scale = d_scale;
    @(posedge clk);
    cyc++;
    changed = 1'b0;
    if (d_vld) begin
      m_acc_c = m_acc_c - m_acc_c / 4 + int'(d_curr);
      m_acc_t = m_acc_t - m_acc_t / 32 + int'(d_torque);
      m_acc_b = m_acc_b - m_acc_b / 4 + int'(d_batt);
      changed = 1'b1;
    end
    if (cyc % 4096 == 0) begin
      cnt = win_edges[cyc / 4096 - 1];
      if (cnt > 255) cnt = 255;
      if (int'(cnt < 2) != m_np) changed = 1'b1;
      m_np = (cnt < 2) ? 1 : 0;
    end
    if (d_incline != last_inc || d_scale != last_scale) changed = 1'b1;
    last_inc = d_incline; last_scale = d_scale;
    stable_cnt = changed ? 0 : stable_cnt + 1;
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic settle();
    d_vld = 1'b0;
    for (int i = 0; i < 20 && stable_cnt < 3; i++) tick();
    if (stable_cnt < 3) begin
      n_cmp++; n_bad++;
      $display("FAIL settle_timeout: stable %0d required 3", stable_cnt);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_avg_curr"},   {1'b0, avg_curr},   13'(m_acc_c / 4));
    chk({tag, "_avg_torque"}, {1'b0, avg_torque}, 13'(m_acc_t / 32));
    chk({tag, "_np"},         {12'd0, not_pedaling}, 13'(m_np));
    chk({tag, "_error"},      error,              exp_err());
  endtask

  initial begin
    logic [12:0] e_old;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("reset_error", error, 13'h0000);
    chk("reset_np", {12'd0, not_pedaling}, 13'h0001);
    chk("reset_avg_curr", {1'b0, avg_curr}, 13'h0000);
    chk("reset_avg_torque", {1'b0, avg_torque}, 13'h0000);

    // Some activity, then reset mid-run
    ppw = 3; d_vld = 1'b1; d_curr = 12'h345; d_torque = 12'h9AB; d_scale = 3'd5;
    run(250);
    d_vld = 1'b0;
    #4 rst_n = 1'b0;
    #1;
    chk("midrst_error", error, 13'h0000);
    chk("midrst_np", {12'd0, not_pedaling}, 13'h0001);
    chk("midrst_avg_curr", {1'b0, avg_curr}, 13'h0000);
    chk("midrst_avg_torque", {1'b0, avg_torque}, 13'h0000);
    @(posedge clk);
    #1;
    cadence_raw = 1'b0; sample_vld = 1'b0;
    rst_n = 1'b1;
    model_reset();
    run(100);
    check_all("post_reset_idle");

    // Nominal assist; not pedaling until the first window closes
    d_torque = 12'h800; d_curr = 12'h100; d_incline = '0; d_scale = 3'd4; d_vld = 1'b1;
    run(1024);
    settle();
    check_all("nominal_prewrap");
    chk("nominal_avg_torque_lit", {1'b0, avg_torque}, 13'h0800);
    chk("nominal_avg_curr_lit", {1'b0, avg_curr}, 13'h0100);
    chk("nominal_prewrap_err_lit", error, 13'h1F00);
    run_to(4096 + 2);
    chk("nominal_np_lit", {12'd0, not_pedaling}, 13'h0000);
    settle();
    check_all("nominal");
    chk("nominal_err_lit", error, 13'h0140);

    // Latency: one sample moves avg_curr, error follows two clocks later
    e_old = exp_err();
    d_vld = 1'b1; d_curr = 12'h200;
    tick();
    d_vld = 1'b0;
    tick();
    chk("latency_1clk_old", error, e_old);
    tick();
    chk("latency_2clk_new", error, exp_err());
    run(5);
    chk("hold_steady", error, exp_err());

    // Negative incline: factor clips to 0
    d_curr = 12'h100; d_torque = 12'h800; d_incline = 13'h1000; d_scale = 3'd4; d_vld = 1'b1;
    run(1024);
    settle();
    check_all("neg_incline");
    chk("neg_incline_err_lit", error, 13'h1F00);

    // Saturation of the target
    d_torque = 12'hFFF; d_curr = 12'h000; d_incline = 13'h01FF; d_scale = 3'd7; d_vld = 1'b1;
    run(1024);
    settle();
    check_all("saturate");
    chk("saturate_err_lit", error, 13'h0FFF);

    // Randomized phases
    for (int t = 0; t < 8; t++) begin
      d_curr = 12'($urandom_range(0, 4095));
      d_torque = 12'($urandom_range(0, 4095));
      d_incline = 13'($urandom);
      d_scale = 3'($urandom_range(0, 7));
      d_vld = 1'b1;
      run(int'($urandom_range(10, 60)));
      settle();
      check_all($sformatf("random%0d", t));
    end

    // Cadence: one pulse per window means not pedaling
    d_curr = 12'h100; d_torque = 12'h800; d_incline = '0; d_scale = 3'd4; d_vld = 1'b1;
    run(200);
    d_vld = 1'b0;
    ppw = 1;
    run_to(8192 + 2);
    chk("cad_three_np", {12'd0, not_pedaling}, 13'(m_np));
    run_to(12288 + 2);
    chk("cad_one_np", {12'd0, not_pedaling}, 13'h0001);
    settle();
    check_all("cad_one");
    chk("cad_one_neg_curr", error, 13'((8192 - m_acc_c / 4) & 'h1FFF));

    // Pulse on the wrap cycle belongs to the next window
    wrap_en = 1'b1;
    run_to(16384 + 2);
    wrap_en = 1'b0;
    chk("wrap_old_window_np", {12'd0, not_pedaling}, 13'(m_np));
    run_to(20480 + 2);
    chk("wrap_new_window_np", {12'd0, not_pedaling}, 13'(m_np));
    chk("wrap_new_window_np_lit", {12'd0, not_pedaling}, 13'h0000);

    // Pulse counter saturation
    ppw = 257;
    run_to(24576 + 2);
    chk("sat257_np", {12'd0, not_pedaling}, 13'(m_np));
    ppw = 300;
    run_to(28672 + 2);
    chk("sat300_np", {12'd0, not_pedaling}, 13'(m_np));
    ppw = 0;
    run_to(32768 + 2);
    chk("zero_pulses_np", {12'd0, not_pedaling}, 13'h0001);
    settle();
    check_all("zero_pulses");

`ifdef SENSOR_COND_LOW_BATT_EN
    ppw = 3;
    run_to(36864 + 2);
    d_torque = 12'h800; d_curr = 12'h100; d_incline = '0; d_scale = 3'd4;
    d_batt = 12'hA00; d_vld = 1'b1;
    run(1024);
    settle();
    check_all("batt_low");
    chk("batt_low_err_lit", error, 13'h1F00);
    d_batt = 12'hB00; d_vld = 1'b1;
    run(1024);
    settle();
    check_all("batt_ok");
    chk("batt_ok_err_lit", error, 13'h0140);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sensor_cond.md
Name: sensor_cond

Overview:
- Front end of the assist loop. Conditions raw sensor readings and produces the signed current error and the not_pedaling flag that the PID stage consumes.
- Sensor handling:
  - Low-pass filters the motor-current and crank-torque samples.
  - Measures cadence from the crank pulse train.
  - Scales filtered torque by incline and the rider assist setting to form a target current.
- Registers error = target - filtered current.

Parameters:
- FAST_SIM, 1, selects the cadence window length: 1 = 2^12 clocks (simulation); 0 = 2^22 clocks (~84 ms at 50 MHz).

Ports:
- clk  input  1  50 MHz system clock
- rst_n  input  1  asynchronous active-low reset
- sample_vld  input  1  one-cycle strobe; curr/torque/batt are valid on this cycle
- curr  input  12  unsigned motor current sample
- torque  input  12  unsigned crank torque sample
- batt  input  12  unsigned battery voltage sample
- incline  input  13  signed incline
- scale  input  3  assist level, 0..7
- cadence_raw  input  1  asynchronous crank pulse
- error  output  13  signed target minus average current, registered
- not_pedaling  output  1  high when latched cadence < 2
- avg_curr  output  12  filtered current
- avg_torque  output  12  filtered torque

Behaviour:
- Reset values: error 0, not_pedaling 1, avg_curr 0, avg_torque 0. All internal state (accumulators, cadence counters, sync flops, pipeline registers) clears.
- Cadence synchronization and counting:
  - cadence_raw passes through a 2-flop synchronizer plus a third flop for rising-edge detect. An edge is seen 3 clocks after the input rises. No glitch filter.
  - A free-running window counter (12 or 22 bits) wraps at all-ones.
  - An 8-bit pulse counter increments on each detected edge and saturates at 255.
  - On the window-wrap cycle, the pulse count is copied to the cadence register and the pulse counter reloads:
    - with 1 if an edge coincides with the wrap (that edge counts toward the new window);
    - otherwise with 0.
  - not_pedaling = (cadence < 2), registered. It changes only at window wrap.
- Current filter (weight 1/4):
  - 14-bit accumulator; on sample_vld, acc <= acc - (acc>>2) + curr.
  - avg_curr = acc[13:2]. Steady state for constant input C is exactly C.
- Torque filter (weight 1/32):
  - 17-bit accumulator; on sample_vld, acc <= acc - (acc>>5) + torque.
  - avg_torque = acc[16:5].
- Target computation (pipeline stage 1, registered):
  - torque_off = avg_torque - 12'h380; clipped to 0 if avg_torque < 12'h380.
  - Incline factor:
    - incline saturates to 10-bit signed (-512..511);
    - add 256 (11-bit signed);
    - clip to 0..511 (9 bits unsigned).
  - prod1 = torque_off * factor (21 bits); t1 = prod1[20:9].
- Scaling and error (pipeline stage 2, registered):
  - prod2 = t1 * scale (15 bits).
  - target = prod2[14:2] saturated to 12'hFFF if bit 14 is set.
  - target is forced to 0 while not_pedaling.
  - error <= {1'b0, target} - {1'b0, avg_curr}. No overflow is possible in 13 bits.
- Latency: a change on avg_curr/avg_torque/incline/scale/not_pedaling appears on error 2 clocks later. Without new samples, error holds steady.
- Reset mid-operation: returns to reset values on the next evaluation of the asynchronous reset. No partial-window cadence is retained.

Optional Feature:
- Macro: SENSOR_COND_LOW_BATT_EN
- Defined:
  - A 12-bit batt filter is active: weight 1/4, same form as the current filter.
  - If filtered batt < 12'hA98, target is forced to 0.
  - 16 clocks of hysteresis are not used; the comparison is evaluated every cycle.
- Undefined: batt is ignored; no filter is instantiated.

Test Plan:
- Reset: rst_n low mid-run -> error 0, not_pedaling 1, avg_curr 0, avg_torque 0 immediately; stay so until pulses/samples arrive.
- Nominal assist:
  - Stimulus: FAST_SIM=1, 3 cadence pulses per 4096-clock window; 1024 samples of torque 12'h800, curr 12'h100; incline 0; scale 4.
  - Response: avg_torque 12'h800, avg_curr 12'h100, not_pedaling 0, error 13'h0140.
- Negative incline: same stimulus with incline 13'h1000 -> factor 0, target 0, error 13'h1F00.
- Saturation: torque 12'hFFF, curr 0, incline 13'h01FF, scale 7 -> target 12'hFFF, error 13'h0FFF.
- Cadence boundaries:
  - 1 pulse per window -> not_pedaling 1, error = -avg_curr.
  - A pulse landing on the wrap cycle is counted in the next window.
  - 300 pulses in one window -> cadence saturates at 255.
- Low battery (macro defined): nominal stimulus with batt 12'hA00 -> error 13'h1F00; batt 12'hB00 -> error 13'h0140.
